tf_stage_sequencer: RTL and testbench
=====================================

Name: tf_stage_sequencer

Overview:
- Sequences twiddle-factor ROM reads for a full radix-2 FFT frame.
- Counts stages and butterflies, computes the twiddle ROM address for each butterfly, drives ROM enable, and emits a read-data-aligned valid plus stage tags.
- Sits between the FFT top-level control and the twiddle BRAM (depth 2^TF_ADDR_LEN, ROM read latency ROM_LAT).
- Replaces the free-running address counter with stage-aware addressing and downstream stall support.

Parameters:
- DATA_NUM_LOG2, 8: log2 of FFT points N; number of stages S = DATA_NUM_LOG2.
- TF_ADDR_LEN, 7: twiddle ROM address width; must equal DATA_NUM_LOG2-1 (ROM holds N/2 factors W_N^k).
- STAGE_W, 3: stage index width; must satisfy 2^STAGE_W >= DATA_NUM_LOG2.
- ROM_LAT, 1: ROM read latency in cycles, 1..4.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse, begin a frame; ignored unless IDLE
- stall  in  1  downstream not ready; freezes issuing
- busy  out  1  high from start acceptance until frame_done inclusive
- tf_addr  out  TF_ADDR_LEN  twiddle ROM address
- tf_en  out  1  ROM read enable; a read is issued when high
- tf_valid  out  1  ROM data valid, tf_en delayed ROM_LAT cycles
- tf_stage  out  STAGE_W  stage of the data currently flagged by tf_valid
- tf_stage_last  out  1  with tf_valid: last butterfly of the stage
- frame_done  out  1  one-cycle pulse with the final tf_valid of the frame

Behaviour:
- Reset (rst=0 at a clk edge):
  - State IDLE.
  - All counters 0.
  - All outputs 0, including the valid/tag delay line.
  - Applies mid-frame: frame aborted, nothing further issued, no frame_done.
- States:
  - IDLE: start=1 -> RUN; stage s=0, butterfly b=0, busy=1 next cycle.
  - RUN: each cycle with stall=0:
    - tf_en=1.
    - tf_addr = (b & ((1<<s)-1)) << (S-1-s), computed within TF_ADDR_LEN bits.
    - b increments. At b=N/2-1, b wraps to 0 and s increments.
    - At s=S-1 and b=N/2-1 (last issue) -> DRAIN.
  - RUN with stall=1: tf_en=0; s, b and tf_addr held. No issue is lost or duplicated.
  - DRAIN: tf_en=0. Wait until the last issued read emerges (ROM_LAT cycles); frame_done pulses with it, then -> IDLE and busy=0 the following cycle.
- Latency and alignment:
  - First tf_en is asserted the cycle after start is accepted.
  - tf_valid, tf_stage and tf_stage_last are delayed exactly ROM_LAT cycles from tf_en, tf_stage/s and (b==N/2-1) respectively.
  - The delay line shifts every cycle regardless of stall. Stall only inserts bubbles; it does not hold ROM output.
- Frame size:
  - Exactly S*N/2 issues per frame.
  - Stage s address sequence has period 2^s with step 2^(S-1-s).
  - Stage 0 is all zeros; the last stage is 0..N/2-1.
- Boundary conditions:
  - start during RUN/DRAIN: ignored.
  - start in the same cycle as frame_done: ignored (state not yet IDLE).
  - stall in IDLE/DRAIN: no effect.
  - stall asserted on the last issue cycle: the last issue is delayed until stall=0.

Decomposition:
- Shared package fft_pkg:
  - DATA_NUM_LOG2 and derived N/2.
  - Stage index width.
  - State encoding IDLE/RUN/DRAIN.
  - Address-function helper (mask-and-shift), reused by data-address generators.
- One natural sub-module: tf_valid_delay, a ROM_LAT-deep shift register carrying {valid, stage, stage_last, frame_last}.

Test Plan:
- DATA_NUM_LOG2=4, ROM_LAT=1, start, no stall:
  - 32 tf_en cycles.
  - tf_addr: stage0 8x0; stage1 0,4,0,4,...; stage2 0,2,4,6,0,2,4,6; stage3 0..7.
  - tf_stage_last at issue indices 7,15,23,31, each one cycle late.
  - frame_done 33 cycles after start.
- Same config with stall=1 on cycles 3-5 of RUN:
  - Address sequence identical to no-stall.
  - tf_valid shows a 3-cycle gap.
  - frame_done 3 cycles later (cycle 36).
- rst=0 mid-stage 2, then release:
  - All outputs 0 the next cycle; no frame_done.
  - A new start runs a full 32-issue frame from addr 0.
- start pulsed during RUN and on the frame_done cycle: ignored; exactly one frame issued.
- ROM_LAT=3, DATA_NUM_LOG2=8:
  - 1024 issues.
  - tf_valid trails tf_en by 3 cycles.
  - The last stage sequence is 0..127.
  - frame_done coincides with the last tf_valid.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT control definitions: default geometry, sequencer states, twiddle address helper.
// Pure declarations; no timing or flow-control behaviour of its own.
package fft_pkg;

    localparam int DEF_DATA_NUM_LOG2 = 8;
    localparam int DEF_HALF_N        = 1 << (DEF_DATA_NUM_LOG2 - 1);
    localparam int DEF_STAGE_W       = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_t;

    // Stage s keeps the low s bits of the butterfly index and scales them up so
    // the twiddle exponent steps by N/2^(s+1) with period 2^s.
    function automatic logic [31:0] stage_addr(
        input logic [31:0] bfly,
        input logic [31:0] stage,
        input logic [31:0] num_stages
    );
        logic [31:0] mask;
        mask = (32'd1 << stage) - 32'd1;
        return (bfly & mask) << (num_stages - 32'd1 - stage);
    endfunction

endpackage

// File: rtl/tf_valid_delay.sv
// Fixed-depth shift register aligning issue tags with twiddle ROM read data.
// Latency LAT cycles; shifts every cycle, no backpressure (stall only creates bubbles upstream).
module tf_valid_delay #(
    parameter int LAT = 1,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] pipe [LAT];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign dout = pipe[LAT-1];

endmodule

// File: rtl/tf_stage_sequencer.sv
// Stage-aware twiddle ROM read sequencer for one radix-2 FFT frame (S*N/2 reads).
// First read the cycle after start; tags/valid trail reads by ROM_LAT; stall holds issue only.
module tf_stage_sequencer
    import fft_pkg::*;
#(
    parameter int DATA_NUM_LOG2 = DEF_DATA_NUM_LOG2,
    parameter int TF_ADDR_LEN   = DEF_DATA_NUM_LOG2 - 1,
    parameter int STAGE_W       = DEF_STAGE_W,
    parameter int ROM_LAT       = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stall,
    output logic                   busy,
    output logic [TF_ADDR_LEN-1:0] tf_addr,
    output logic                   tf_en,
    output logic                   tf_valid,
    output logic [STAGE_W-1:0]     tf_stage,
    output logic                   tf_stage_last,
    output logic                   frame_done
);

    localparam int HALF_N = 1 << (DATA_NUM_LOG2 - 1);
    localparam logic [TF_ADDR_LEN-1:0] BFLY_LAST  = TF_ADDR_LEN'(HALF_N - 1);
    localparam logic [STAGE_W-1:0]     STAGE_LAST = STAGE_W'(DATA_NUM_LOG2 - 1);
    localparam int TAG_W = STAGE_W + 3;

    seq_state_t               state_q, state_d;
    logic [STAGE_W-1:0]       stage_q, stage_d;
    logic [TF_ADDR_LEN-1:0]   bfly_q, bfly_d;
    logic                     issue_stage_last;
    logic                     issue_frame_last;
    logic [TAG_W-1:0]         tag_in;
    logic [TAG_W-1:0]         tag_out;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            stage_q <= '0;
            bfly_q  <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            bfly_q  <= bfly_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        stage_d          = stage_q;
        bfly_d           = bfly_q;
        tf_en            = 1'b0;
        issue_stage_last = 1'b0;
        issue_frame_last = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    stage_d = '0;
                    bfly_d  = '0;
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    tf_en = 1'b1;
                    if (bfly_q == BFLY_LAST) begin
                        bfly_d           = '0;
                        issue_stage_last = 1'b1;
                        if (stage_q == STAGE_LAST) begin
                            issue_frame_last = 1'b1;
                            stage_d          = '0;
                            state_d          = ST_DRAIN;
                        end else begin
                            stage_d = stage_q + STAGE_W'(1);
                        end
                    end else begin
                        bfly_d = bfly_q + TF_ADDR_LEN'(1);
                    end
                end
            end
            ST_DRAIN: begin
                // The final read's tag leaving the delay line marks the end of the frame.
                if (frame_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy    = (state_q != ST_IDLE);
    assign tf_addr = TF_ADDR_LEN'(stage_addr(32'(bfly_q), 32'(stage_q), 32'(DATA_NUM_LOG2)));
    assign tag_in  = {tf_en, stage_q, issue_stage_last, issue_frame_last};

    tf_valid_delay #(
        .LAT (ROM_LAT),
        .W   (TAG_W)
    ) u_valid_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (tag_in),
        .dout (tag_out)
    );

    assign {tf_valid, tf_stage, tf_stage_last, frame_done} = tag_out;

endmodule

// File: tb/tb_tf_stage_sequencer.sv
// Directed bench: N=16/ROM_LAT=1 instance for sequencing corners, N=256/ROM_LAT=3 for full-size alignment.
module tb_tf_stage_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start4, stall4, start8, stall8;
    logic       busy4, tf_en4, tf_valid4, tf_stage_last4, frame_done4;
    logic [2:0] tf_addr4;
    logic [1:0] tf_stage4;
    logic       busy8, tf_en8, tf_valid8, tf_stage_last8, frame_done8;
    logic [6:0] tf_addr8;
    logic [2:0] tf_stage8;

    int total  = 0;
    int passed = 0;

    tf_stage_sequencer #(
        .DATA_NUM_LOG2 (4),
        .TF_ADDR_LEN   (3),
        .STAGE_W       (2),
        .ROM_LAT       (1)
    ) dut4 (
        .clk           (clk),
        .rst           (rst),
        .start         (start4),
        .stall         (stall4),
        .busy          (busy4),
        .tf_addr       (tf_addr4),
        .tf_en         (tf_en4),
        .tf_valid      (tf_valid4),
        .tf_stage      (tf_stage4),
        .tf_stage_last (tf_stage_last4),
        .frame_done    (frame_done4)
    );

    tf_stage_sequencer #(
        .DATA_NUM_LOG2 (8),
        .TF_ADDR_LEN   (7),
        .STAGE_W       (3),
        .ROM_LAT       (3)
    ) dut8 (
        .clk           (clk),
        .rst           (rst),
        .start         (start8),
        .stall         (stall8),
        .busy          (busy8),
        .tf_addr       (tf_addr8),
        .tf_en         (tf_en8),
        .tf_valid      (tf_valid8),
        .tf_stage      (tf_stage8),
        .tf_stage_last (tf_stage_last8),
        .frame_done    (frame_done8)
    );

    // N=16 twiddle address table: stage0 all 0, stage1 0/4, stage2 0,2,4,6, stage3 0..7.
    function automatic logic [2:0] exp_addr4(input int k);
        if (k < 8)       return 3'd0;
        else if (k < 16) return 3'((k % 2) * 4);
        else if (k < 24) return 3'((k % 4) * 2);
        else             return 3'(k - 24);
    endfunction

    task automatic cyc4(input logic st, input logic sl);
        @(posedge clk);
        #1;
        start4 = st;
        stall4 = sl;
        #1;
    endtask

    task automatic cyc8(input logic st);
        @(posedge clk);
        #1;
        start8 = st;
        stall8 = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; start4 = 0; stall4 = 0; start8 = 0; stall8 = 0;
        repeat (2) @(posedge clk);
        #2;
        total++;
        if ({busy4, tf_en4, tf_addr4, tf_valid4, tf_stage4, tf_stage_last4, frame_done4} !== 10'd0) begin
            $display("FAIL reset_dut4 outputs=%b expected all zero",
                     {busy4, tf_en4, tf_addr4, tf_valid4, tf_stage4, tf_stage_last4, frame_done4});
        end else passed++;
        total++;
        if ({busy8, tf_en8, tf_addr8, tf_valid8, tf_stage8, tf_stage_last8, frame_done8} !== 15'd0) begin
            $display("FAIL reset_dut8 outputs=%b expected all zero",
                     {busy8, tf_en8, tf_addr8, tf_valid8, tf_stage8, tf_stage_last8, frame_done8});
        end else passed++;
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // One N=16 frame: start at cycle 0, optional stall window, optional stray starts
    // (mid-RUN and on the frame_done cycle); checked cycle by cycle against the table.
    task automatic test_frame4(input int stall_from, input int stall_len,
                               input bit extra_starts, input string name);
        int  issued   = 0;
        bit  prev_en  = 0;
        int  prev_k   = 0;
        bit  done_seen = 0;
        int  done_cyc = -1;
        int  en_cnt   = 0;
        bit  sl, st, exp_en;
        cyc4(1'b1, 1'b0);
        total++;
        if (busy4 !== 1'b0) begin
            $display("FAIL %s busy_before_accept got=%b expected=0", name, busy4);
        end else passed++;
        for (int c = 1; c <= 40; c++) begin
            sl = (c >= stall_from) && (c < stall_from + stall_len);
            st = extra_starts && (c == 10 || c == 33 + stall_len);
            cyc4(st, sl);
            exp_en = (issued < 32) && !sl;
            total++;
            if (busy4 !== !done_seen) begin
                $display("FAIL %s busy cycle=%0d got=%b expected=%b", name, c, busy4, !done_seen);
            end else passed++;
            total++;
            if (tf_en4 !== exp_en) begin
                $display("FAIL %s tf_en cycle=%0d got=%b expected=%b", name, c, tf_en4, exp_en);
            end else passed++;
            if (exp_en) begin
                total++;
                if (tf_addr4 !== exp_addr4(issued)) begin
                    $display("FAIL %s tf_addr issue=%0d got=%0d expected=%0d",
                             name, issued, tf_addr4, exp_addr4(issued));
                end else passed++;
            end
            total++;
            if ({tf_valid4, frame_done4} !== {prev_en, prev_en && prev_k == 31}) begin
                $display("FAIL %s valid/done cycle=%0d got=%b%b expected=%b%b", name, c,
                         tf_valid4, frame_done4, prev_en, prev_en && prev_k == 31);
            end else passed++;
            if (prev_en) begin
                total++;
                if ({tf_stage4, tf_stage_last4} !== {2'(prev_k / 8), prev_k % 8 == 7}) begin
                    $display("FAIL %s stage_tag issue=%0d got=%0d/%b expected=%0d/%b", name, prev_k,
                             tf_stage4, tf_stage_last4, prev_k / 8, prev_k % 8 == 7);
                end else passed++;
            end
            if (frame_done4 && done_cyc < 0) done_cyc = c;
            if (tf_en4) en_cnt++;
            if (prev_en && prev_k == 31) done_seen = 1;
            prev_en = exp_en;
            prev_k  = issued;
            if (exp_en) issued++;
        end
        cyc4(1'b0, 1'b0);
        total++;
        if (en_cnt !== 32) begin
            $display("FAIL %s issue_count got=%0d expected=32", name, en_cnt);
        end else passed++;
        total++;
        if (done_cyc !== 33 + stall_len) begin
            $display("FAIL %s frame_done_cycle got=%0d expected=%0d", name, done_cyc, 33 + stall_len);
        end else passed++;
    endtask

    task automatic test_reset_mid_frame();
        bit bad = 0;
        cyc4(1'b1, 1'b0);
        for (int c = 1; c <= 19; c++) cyc4(1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        total++;
        if ({busy4, tf_en4, tf_addr4, tf_valid4, tf_stage4, tf_stage_last4, frame_done4} !== 10'd0) begin
            $display("FAIL reset_mid_frame outputs=%b expected all zero",
                     {busy4, tf_en4, tf_addr4, tf_valid4, tf_stage4, tf_stage_last4, frame_done4});
        end else passed++;
        for (int c = 0; c < 30; c++) begin
            cyc4(1'b0, 1'b0);
            if (busy4 || tf_en4 || tf_valid4 || frame_done4) bad = 1;
        end
        total++;
        if (bad !== 1'b0) begin
            $display("FAIL reset_mid_frame activity_after_abort got=%b expected=0", bad);
        end else passed++;
        test_frame4(0, 0, 1'b0, "post_reset");
    endtask

    task automatic test_big_rom_lat3();
        int en_cnt = 0;
        bit exp_en, exp_valid;
        int k, v;
        cyc8(1'b1);
        for (int c = 1; c <= 1035; c++) begin
            cyc8(1'b0);
            exp_en = (c <= 1024);
            k = c - 1;
            total++;
            if (tf_en8 !== exp_en) begin
                $display("FAIL lat3 tf_en cycle=%0d got=%b expected=%b", c, tf_en8, exp_en);
            end else passed++;
            if (exp_en && (k < 128 || k >= 896)) begin
                total++;
                if (tf_addr8 !== ((k < 128) ? 7'd0 : 7'(k - 896))) begin
                    $display("FAIL lat3 tf_addr issue=%0d got=%0d expected=%0d",
                             k, tf_addr8, (k < 128) ? 0 : k - 896);
                end else passed++;
            end
            exp_valid = (c >= 4) && (c <= 1027);
            total++;
            if ({tf_valid8, frame_done8} !== {exp_valid, c == 1027}) begin
                $display("FAIL lat3 valid/done cycle=%0d got=%b%b expected=%b%b",
                         c, tf_valid8, frame_done8, exp_valid, c == 1027);
            end else passed++;
            if (exp_valid) begin
                v = c - 4;
                total++;
                if ({tf_stage8, tf_stage_last8} !== {3'(v / 128), v % 128 == 127}) begin
                    $display("FAIL lat3 stage_tag issue=%0d got=%0d/%b expected=%0d/%b",
                             v, tf_stage8, tf_stage_last8, v / 128, v % 128 == 127);
                end else passed++;
            end
            if (tf_en8) en_cnt++;
        end
        total++;
        if (en_cnt !== 1024) begin
            $display("FAIL lat3 issue_count got=%0d expected=1024", en_cnt);
        end else passed++;
        total++;
        if (busy8 !== 1'b0) begin
            $display("FAIL lat3 busy_after_frame got=%b expected=0", busy8);
        end else passed++;
    endtask

    initial begin
        test_reset();
        test_frame4(0, 0, 1'b0, "no_stall");
        test_frame4(3, 3, 1'b0, "stall_3_5");
        test_frame4(32, 2, 1'b0, "stall_last_issue");
        test_reset_mid_frame();
        test_frame4(0, 0, 1'b1, "stray_starts");
        test_big_rom_lat3();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
